// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared types and constants for the AXI4-Lite initiator.
// Holds the FSM state encoding, AXI response codes and the default watchdog.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator with a
// valid/ready command port, one-cycle response strobe and phase watchdog.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 30,
    parameter int TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            wr_q, wr_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_write_q, rsp_write_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic            busy_q, busy_d;
    logic            timeout_hit;
    logic            abort;
    logic            in_phase;

    assign cmd_ready     = (state_q == IDLE) && !M_AXI_ARESET;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

    // Next-state, next-output and watchdog logic for the transaction FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        wr_d          = wr_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;
        timeout_hit   = TO_EN && (cnt_q == CNT_MAX);
        in_phase      = (state_q == WR_AW_W) || (state_q == WR_B) ||
                        (state_q == RD_AR) || (state_q == RD_R);

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    wr_d    = cmd_write;
                    if (cmd_write) begin
                        state_d   = WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY) wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            WR_B: begin
                if (M_AXI_BVALID) begin
                    bready_d      = 1'b0;
                    state_d       = RESP;
                    rsp_write_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = M_AXI_BRESP;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RD_AR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RD_R: begin
                if (M_AXI_RVALID) begin
                    rready_d      = 1'b0;
                    state_d       = RESP;
                    rsp_write_d   = 1'b0;
                    rsp_rdata_d   = M_AXI_RDATA;
                    rsp_resp_d    = M_AXI_RRESP;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stuck slave is abandoned: every handshake line falls together.
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            state_d       = RESP;
            rsp_write_d   = wr_q;
            rsp_rdata_d   = '0;
            rsp_resp_d    = RESP_SLVERR;
            rsp_timeout_d = 1'b1;
        end

        if (state_d == state_q && in_phase) begin
            cnt_d = cnt_q + 1'b1;
        end

        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // State, latched command and registered outputs.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            wr_q          <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            wr_q          <= wr_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: random and directed checks of the AXI4-Lite initiator
// against a behavioural slave and a transaction-level reference model.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int AW = 30;
    localparam int TO = 16;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_write, rsp_timeout, busy;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;

    axi_lite_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata),
        .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata),
        .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    // Slave behaviour knobs
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          ar_never = 1'b0, r_force = 1'b0;
    logic [31:0] r_data_cfg = '0;
    logic [1:0]  b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Behavioural AXI-Lite slave with programmable wait states
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit          aw_got, w_got, ar_got;
    logic [AW-1:0] s_aw, s_ar, wa, ra;
    logic [31:0] s_wd, wd;
    logic [3:0]  s_ws, ws;
    logic [31:0] s_mem [64];
    logic        aw_hs, w_hs, ar_hs;

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign arready = arvalid && !ar_never && (ar_cnt >= ar_dly);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign wa      = aw_hs ? awaddr : s_aw;
    assign wd      = w_hs ? wdata : s_wd;
    assign ws      = w_hs ? wstrb : s_ws;
    assign ra      = ar_hs ? araddr : s_ar;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 0; w_got <= 0; ar_got <= 0;
            s_aw <= '0; s_ar <= '0; s_wd <= '0; s_ws <= '0;
            bvalid <= 0; rvalid <= 0; bresp <= 0; rresp <= 0; rdata <= 0;
            for (int i = 0; i < 64; i++) s_mem[i] <= '0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (aw_hs) begin s_aw <= awaddr; aw_got <= 1; end
            if (w_hs) begin s_wd <= wdata; s_ws <= wstrb; w_got <= 1; end
            if (ar_hs) begin s_ar <= araddr; ar_got <= 1; end
            if (bvalid && bready) begin
                bvalid <= 0; aw_got <= 0; w_got <= 0;
            end else if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid) begin
                if (b_cnt >= b_dly) begin
                    bvalid <= 1; bresp <= b_resp_cfg; b_cnt <= 0;
                    s_mem[wa[7:2]] <= merge(s_mem[wa[7:2]], wd, ws);
                end else b_cnt <= b_cnt + 1;
            end
            if (rvalid && rready) begin
                rvalid <= 0; ar_got <= 0;
            end else if ((ar_got || ar_hs) && !rvalid) begin
                if (r_cnt >= r_dly) begin
                    rvalid <= 1; rresp <= r_resp_cfg; r_cnt <= 0;
                    rdata <= r_force ? r_data_cfg : s_mem[ra[7:2]];
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    // Bus activity counters and response capture
    int   awv_cyc = 0, wv_cyc = 0, arv_cyc = 0, rr_cyc = 0;
    int   awhs_cnt = 0, rsp_cnt = 0, ovl_cnt = 0, acc_cnt = 0;
    rsp_t got_q [$];

    always @(negedge clk) begin
        if (awvalid) awv_cyc <= awv_cyc + 1;
        if (wvalid) wv_cyc <= wv_cyc + 1;
        if (arvalid) arv_cyc <= arv_cyc + 1;
        if (rready) rr_cyc <= rr_cyc + 1;
        if (aw_hs) awhs_cnt <= awhs_cnt + 1;
        if (busy && cmd_ready) ovl_cnt <= ovl_cnt + 1;
        if (rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1;
            got_q.push_back({rsp_write, rsp_rdata, rsp_resp, rsp_timeout});
        end
    end

    always @(posedge clk)
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outvec();
        return {16'h0, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                rsp_write, rsp_timeout, busy, rsp_resp, |awaddr, |araddr,
                |wdata, |wstrb, |rsp_rdata};
    endfunction

    // Reference model: word memory plus expected response per command
    logic [31:0] ref_mem [64];

    function automatic rsp_t predict(input bit wr, input logic [AW-1:0] a,
                                     input logic [31:0] d, input logic [3:0] s,
                                     input bit to);
        rsp_t e;
        e.wr = wr;
        e.to = to;
        if (to) begin
            e.rdata = '0; e.resp = RESP_SLVERR;
        end else if (wr) begin
            e.rdata = '0; e.resp = b_resp_cfg;
            ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, s);
        end else begin
            e.rdata = r_force ? r_data_cfg : ref_mem[a[7:2]];
            e.resp = r_resp_cfg;
        end
        return e;
    endfunction

    task automatic cmp_rsp(input string tag, input rsp_t g, input rsp_t e);
        check({tag, "_wr"}, 32'(g.wr), 32'(e.wr));
        check({tag, "_rdata"}, g.rdata, e.rdata);
        check({tag, "_resp"}, 32'(g.resp), 32'(e.resp));
        check({tag, "_timeout"}, 32'(g.to), 32'(e.to));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check("cmd_ready_wait", 32'(cmd_ready), 1);
    endtask

    task automatic run(input bit wr, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input bit to, output int lat);
        rsp_t e;
        e = predict(wr, a, d, s, to);
        @(negedge clk);
        wait_ready();
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        #1;
        if (got_q.size() == 0) check("rsp_seen", 0, 1);
        else cmp_rsp("rsp", got_q.pop_front(), e);
        if (!to && wr) begin
            check("awaddr", 32'(s_aw), 32'(a));
            check("wdata", s_wd, d);
            check("wstrb", 32'(s_ws), 32'(s));
        end else if (!to) begin
            check("araddr", 32'(s_ar), 32'(a));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, a0, b0, c0, d0, n;
        rsp_t bq [$];
        logic [AW-1:0] la;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 0);
        check("reset_outputs", outvec(), 0);
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", 32'(cmd_ready), 1);

        // zero-wait write then read-back
        a0 = awv_cyc; b0 = wv_cyc;
        run(1, 30'h0000_000C, 32'h0000_0040, 4'hF, 0, lat);
        check("wr_latency", lat, 3);
        check("wr_awvalid_cycles", awv_cyc - a0, 1);
        check("wr_wvalid_cycles", wv_cyc - b0, 1);
        check("slave_reg_c", s_mem[3], 32'h40);
        run(0, 30'h0000_000C, 0, 0, 0, lat);
        check("rd_latency", lat, 3);

        // AWREADY two cycles ahead of WREADY
        aw_dly = 2; w_dly = 4;
        a0 = awv_cyc; b0 = wv_cyc; c0 = awhs_cnt; d0 = rsp_cnt;
        run(1, 30'h0000_0010, 32'h1234_5678, 4'hF, 0, lat);
        check("split_latency", lat, 7);
        check("split_awvalid_cycles", awv_cyc - a0, 3);
        check("split_wvalid_cycles", wv_cyc - b0, 5);
        check("split_aw_handshakes", awhs_cnt - c0, 1);
        check("split_rsp_count", rsp_cnt - d0, 1);
        aw_dly = 0; w_dly = 0;

        // slow read with forced data and SLVERR
        r_dly = 5; r_force = 1; r_data_cfg = 32'hDEAD_BEEF;
        r_resp_cfg = RESP_SLVERR;
        a0 = rr_cyc;
        run(0, 30'h0000_0004, 0, 0, 0, lat);
        check("slow_rd_latency", lat, 8);
        check("slow_rd_rready_cycles", rr_cyc - a0, 6);
        r_dly = 0; r_force = 0; r_resp_cfg = RESP_OKAY;

        // watchdog on a slave that never accepts AR
        ar_never = 1;
        a0 = arv_cyc;
        run(0, 30'h0000_0008, 0, 0, 1, lat);
        check("to_latency", lat, TO + 1);
        check("to_arvalid_cycles", arv_cyc - a0, TO);
        @(negedge clk);
        check("to_cmd_ready_after", 32'(cmd_ready), 1);
        ar_never = 0;

        // reset while waiting in WR_B
        b_dly = 10;
        @(negedge clk);
        wait_ready();
        cmd_write = 1; cmd_addr = 30'h20; cmd_wdata = 32'hA5A5_A5A5;
        cmd_wstrb = 4'hF; cmd_valid = 1;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!bready && n < 50) begin @(negedge clk); n++; end
        check("reached_wr_b", 32'(bready), 1);
        d0 = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", outvec(), 0);
        check("midrst_cmd_ready", 32'(cmd_ready), 0);
        rst = 1'b0;
        b_dly = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (5) @(negedge clk);
        check("midrst_no_rsp", rsp_cnt - d0, 0);
        check("midrst_no_capture", got_q.size(), 0);
        run(1, 30'h0000_0024, 32'hCAFE_0001, 4'hF, 0, lat);
        check("post_rst_wr_latency", lat, 3);
        run(0, 30'h0000_0024, 0, 0, 0, lat);

        // ten back-to-back alternating commands, cmd_valid held high
        a0 = acc_cnt; b0 = ovl_cnt; c0 = rsp_cnt;
        la = '0;
        @(negedge clk);
        cmd_valid = 1;
        for (int i = 0; i < 10; i++) begin
            cmd_write = (i % 2 == 0);
            if (cmd_write) la = 30'($urandom);
            cmd_addr = la;
            cmd_wdata = $urandom;
            cmd_wstrb = 4'($urandom_range(1, 15));
            wait_ready();
            bq.push_back(predict(cmd_write, cmd_addr, cmd_wdata,
                                 cmd_wstrb, 0));
            @(negedge clk);
        end
        cmd_valid = 0;
        n = 0;
        while (got_q.size() < 10 && n < 200) begin @(negedge clk); n++; end
        check("b2b_accepts", acc_cnt - a0, 10);
        check("b2b_rsp_count", rsp_cnt - c0, 10);
        check("b2b_busy_ready_overlap", ovl_cnt - b0, 0);
        while (bq.size() > 0 && got_q.size() > 0)
            cmp_rsp("b2b", got_q.pop_front(), bq.pop_front());
        check("b2b_leftover", bq.size(), 0);

        // randomized commands with random wait states and responses
        for (int i = 0; i < 24; i++) begin
            bit wr;
            int exp_lat;
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            b_resp_cfg = 2'($urandom_range(0, 3));
            r_resp_cfg = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            exp_lat = wr ? ((aw_dly > w_dly ? aw_dly : w_dly) + b_dly + 3)
                         : (ar_dly + r_dly + 3);
            run(wr, 30'($urandom), $urandom, 4'($urandom_range(0, 15)),
                0, lat);
            check("rand_latency", lat, exp_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
